// File: rtl/wb_frame_buf.sv
// Double-buffered frame store: the Wishbone slave writes the back bank while the LED scan reads the front bank.
// Optional macro WB_FRAME_BUF_ERR_EN adds wbs_err for out-of-range accesses.
module wb_frame_buf #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  input  logic                  wbs_write,
  output logic                  wbs_ack,
`ifdef WB_FRAME_BUF_ERR_EN
  output logic                  wbs_err,
`endif
  input  logic [DEPTH_LOG2-1:0] scan_addr,
  output logic [DATA_WIDTH-1:0] scan_data,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_bank
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Handshake: a request is sampled in IDLE when strobe & cycle are high; the
  // slave answers with exactly one ack (or err) cycle in ACK, then returns to IDLE.
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   mem [2*DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    req;
  logic                    in_range;
  logic                    take;
  logic                    swap_pending;
  logic                    swap_go;
  logic [DEPTH_LOG2-1:0]   word;
`ifdef WB_FRAME_BUF_ERR_EN
  logic                    oor_q;
`endif

  assign req      = wbs_strobe & wbs_cycle;
  assign in_range = (wbs_address >> DEPTH_LOG2) == '0;
  assign word     = wbs_address[DEPTH_LOG2-1:0];
  assign take     = (state == IDLE) & req;
  // A swap only fires in an idle cycle that is not starting a bus transfer.
  assign swap_go  = swap_pending & (state == IDLE) & ~req;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wbs_ack      = 1'b0;
    wbs_readdata = '0;
`ifdef WB_FRAME_BUF_ERR_EN
    wbs_err      = 1'b0;
    if (state == ACK) begin
      wbs_ack      = ~oor_q;
      wbs_err      = oor_q;
      wbs_readdata = rdata_q;
    end
`else
    if (state == ACK) begin
      wbs_ack      = 1'b1;
      wbs_readdata = rdata_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
`ifdef WB_FRAME_BUF_ERR_EN
      oor_q   <= 1'b0;
`endif
    end else if (take) begin
      rdata_q <= (in_range && !wbs_write) ? mem[{~front_bank, word}] : '0;
`ifdef WB_FRAME_BUF_ERR_EN
      oor_q   <= ~in_range;
`endif
    end
  end

  // Bank storage is never cleared; reset only blocks a write on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && take && wbs_write && in_range)
      mem[{~front_bank, word}] <= wbs_writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) scan_data <= '0;
    else       scan_data <= mem[{front_bank, scan_addr}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= swap_go;
      if (swap_go) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/wb_frame_buf.md
WB_FRAME_BUF -- requirements
Module: wb_frame_buf

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of the Wishbone word address.
REQ-002 Parameter DATA_WIDTH, default 32: width of Wishbone and scan data.
REQ-003 Parameter DEPTH_LOG2, default 8: log2 of words per bank; DEPTH = 2**DEPTH_LOG2.
REQ-004 Port clk  in  1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port wbs_address  in  ADDR_WIDTH: word address from the bus master.
REQ-007 Port wbs_writedata  in  DATA_WIDTH: write data.
REQ-008 Port wbs_readdata  out  DATA_WIDTH: read data, valid while wbs_ack is high.
REQ-009 Port wbs_strobe, wbs_cycle, wbs_write  in  1 each: Wishbone classic strobe, cycle and write-enable.
REQ-010 Port wbs_ack  out  1: single-cycle transfer acknowledge.
REQ-011 Port scan_addr  in  DEPTH_LOG2: front-bank read address from the LED scan logic.
REQ-012 Port scan_data  out  DATA_WIDTH: front-bank word at scan_addr.
REQ-013 Port swap_req  in  1: request to exchange the front and back banks.
REQ-014 Port swap_done  out  1: one-cycle pulse when a swap has taken effect.
REQ-015 Port front_bank  out  1: index (0/1) of the bank currently scanned out.

Function
REQ-016 The block SHALL hold two banks of DEPTH x DATA_WIDTH words; Wishbone accesses SHALL target only the back bank (~front_bank).
REQ-017 The bus FSM SHALL have states IDLE and ACK; IDLE->ACK when wbs_strobe & wbs_cycle; ACK->IDLE unconditionally after one cycle.
REQ-018 wbs_ack SHALL be high exactly in ACK, one cycle after the request is sampled, and never on consecutive cycles.
REQ-019 A write SHALL commit at the IDLE->ACK edge; a read SHALL present registered data in ACK.
REQ-020 In-range address is wbs_address < DEPTH; out-of-range writes SHALL be dropped and out-of-range reads SHALL return 0, with normal ack.
REQ-021 wbs_readdata SHALL be 0 whenever wbs_ack is low.
REQ-022 Requests with wbs_cycle low, or wbs_strobe low, SHALL be ignored.
REQ-023 scan_data SHALL equal front_bank[scan_addr] with one-cycle latency, independent of bus activity.
REQ-024 swap_req SHALL set a pending flag; the swap SHALL execute on the first cycle the FSM is IDLE with no new request sampled, toggling front_bank.
REQ-025 swap_done SHALL pulse for exactly the cycle after front_bank toggles; swap_req asserted while pending SHALL not queue a second swap.
REQ-026 If swap_req and a bus request arrive in the same IDLE cycle, the bus request SHALL win; the swap SHALL follow after its ACK.
REQ-027 scan_data after a swap SHALL reflect the new front bank from the first scan read issued after the toggle.

Reset
REQ-028 Reset SHALL force FSM to IDLE, wbs_ack=0, wbs_readdata=0, swap_done=0, pending swap cleared, front_bank=0, scan_data=0.
REQ-029 Reset mid-transfer SHALL abort it without ack; bank contents SHALL be left unchanged.

Configuration
REQ-030 Macro WB_FRAME_BUF_ERR_EN: when defined, port wbs_err (out, 1) SHALL exist and out-of-range accesses SHALL raise wbs_err instead of wbs_ack, same timing; when undefined, wbs_err SHALL be absent and REQ-020 applies.

Verification
REQ-031 After reset: write 0xDEADBEEF to addr 5, read addr 5 -> ack 1 cycle after strobe, readdata 0xDEADBEEF, front_bank=0.
REQ-032 Write back bank addr 3 = 0x12345678, pulse swap_req -> swap_done pulses, front_bank=1, scan_addr=3 gives 0x12345678 next cycle.
REQ-033 Back-to-back strobes held high 6 cycles -> exactly 3 ack pulses, alternating.
REQ-034 swap_req same cycle as write request -> ack first, then front_bank toggles the following cycle; one swap_done only.
REQ-035 Read addr DEPTH (256) -> readdata 0 with ack (wbs_err=1 and no ack with WB_FRAME_BUF_ERR_EN).
REQ-036 Assert reset during ACK -> wbs_ack 0 next cycle, front_bank 0, earlier written data still readable.
